mac_output_stage: RTL and testbench
===================================

// Module: mac_output_stage
// PURPOSE
//  Downstream neighbour of the fixed-point multiply-accumulate stage. Uses the same new_sum
//  pulse the MAC receives to capture each completed dot-product sum from the MAC data_out.
//  Adds a per-channel bias, applies optional ReLU and saturates to BW bits. Buffers results
//  in a small FIFO under a valid/ready handshake toward the next layer.
// PARAMETERS
//  BW          16  width of MAC sum, bias and output (two's complement)
//  LAT         3   cycles from new_sum sampled high to finished previous sum on mac_in (>=1)
//  NUM_OUT     16  output channels per frame; bias table depth, channel counter modulus (>=2)
//  FIFO_DEPTH  4   output FIFO entries (power of 2, >=2)
//  RELU        1   1: clamp negative results to 0; 0: pass signed
// PORTS
//  clk           in   1                   clock, rising edge
//  rst_n         in   1                   asynchronous active-low reset
//  new_sum       in   1                   same pulse driven to the MAC new_sum input
//  mac_in        in   BW                  MAC data_out
//  bias_wr_en    in   1                   bias table write strobe
//  bias_wr_addr  in   $clog2(NUM_OUT)     bias entry index
//  bias_wr_data  in   BW                  signed bias value
//  out_ready     in   1                   downstream accepts out_data
//  out_valid     out  1                   out_data/out_chan valid
//  out_data      out  BW                  biased, activated, saturated result
//  out_chan      out  $clog2(NUM_OUT)     channel index of out_data
//  fifo_count    out  $clog2(FIFO_DEPTH)+1  FIFO occupancy
//  overflow      out  1                   sticky: a result was dropped on a full FIFO
// BEHAVIOUR
//  Reset (async, rst_n=0): all outputs 0; armed=0; channel counter=0; FIFO empty; pipeline
//   valids 0; bias table cleared to 0. Reset mid-frame discards all in-flight results.
//  Arm: the first new_sum after reset sets armed and yields no capture; it only starts the
//   first sum. Each later new_sum marks the end of the previous sum.
//  Tap: LAT-deep shift register of (new_sum & armed). Tap high at edge E0+LAT, where E0 is
//   the edge sampling new_sum. At that edge: s1 <= sext(mac_in)+sext(bias[chan]) in BW+1
//   bits; s1_chan <= chan; chan <= (chan==NUM_OUT-1) ? 0 : chan+1.
//  Stage 2, edge E0+LAT+1: r = RELU && s1<0 ? 0 : s1; s2 <= saturate(r) to
//   [-2^(BW-1), 2^(BW-1)-1].
//  Push, edge E0+LAT+2: write {s2_chan, s2} to FIFO. out_valid is visible the following
//   cycle if the FIFO was empty.
//  Back-to-back new_sum pulses, one per cycle, are legal; the pipeline has no stalls.
//  Bias write: takes effect at the next edge. A write to an entry in the same cycle its
//   tap fires uses the old value.
//  FIFO: first-word fall-through. out_valid = (count != 0). Pop when out_valid & out_ready.
//   out_data/out_chan are stable while out_valid & !out_ready.
//  Full push: the push is accepted if count < FIFO_DEPTH, or if a pop occurs in the same
//   cycle. Otherwise the result is dropped, overflow sets and holds until reset, and the
//   channel counter still advances.
//  Empty: out_ready with count==0 has no effect. fifo_count never wraps.
//  new_sum while a sum is still in the delay line is legal; taps are independent.
// TESTING
//  T1 LAT=3, bias[0]=5, new_sum at E0 and E0+32, mac_in=100 at E0+35, out_ready=1 ->
//     out_valid 1 cycle, out_data=105, out_chan=0, after E0+37.
//  T2 bias[1]=-10, sum=4, RELU=1 -> out_data=0. Same case with RELU=0 -> 0xFFFA.
//  T3 sum=0x7FF0, bias=0x0100 -> 0x7FFF. RELU=0, sum=0x8005, bias=-16 -> 0x8000.
//  T4 out_ready=0, 6 sums, FIFO_DEPTH=4 -> fifo_count=4, overflow=1, first 4 chans 0..3
//     retained. Then raise out_ready -> those 4 drained in order, next chan emitted is 6.
//  T5 NUM_OUT=16, 17 sums -> out_chan sequence 0..15,0. The first new_sum after reset
//     produces no output.
//  T6 rst_n low for 1 cycle mid-frame with 2 results queued -> out_valid=0, fifo_count=0,
//     and the next frame restarts at chan 0 after a re-arm pulse.

Source files
------------

// File: rtl/mac_output_stage.sv
// mac_output_stage: captures MAC sums, adds per-channel bias, applies ReLU/saturation, buffers in a FWFT FIFO
module mac_output_stage #(
  parameter int BW = 16,
  parameter int LAT = 3,
  parameter int NUM_OUT = 16,
  parameter int FIFO_DEPTH = 4,
  parameter bit RELU = 1'b1
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            new_sum,
  input  logic [BW-1:0]                   mac_in,
  input  logic                            bias_wr_en,
  input  logic [$clog2(NUM_OUT)-1:0]      bias_wr_addr,
  input  logic [BW-1:0]                   bias_wr_data,
  input  logic                            out_ready,
  output logic                            out_valid,
  output logic [BW-1:0]                   out_data,
  output logic [$clog2(NUM_OUT)-1:0]      out_chan,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_count,
  output logic                            overflow
);
  localparam int CW = $clog2(NUM_OUT);
  localparam int AW = $clog2(FIFO_DEPTH);
  logic armed_q, armed_d, s1_v_q, s1_v_d, s2_v_q, s2_v_d, ovf_q, ovf_d;
  logic [LAT-1:0] tap_q, tap_d;
  logic [CW-1:0] chan_q, chan_d, s1_chan_q, s1_chan_d, s2_chan_q, s2_chan_d;
  logic [BW:0] s1_q, s1_d, r;
  logic [BW-1:0] s2_q, s2_d;
  logic [BW-1:0] bias_q [NUM_OUT];
  logic [BW-1:0] bias_d [NUM_OUT];
  logic [CW+BW-1:0] mem_q [FIFO_DEPTH];
  logic [CW+BW-1:0] mem_d [FIFO_DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0] cnt_q, cnt_d;
  logic fire, pop, push;

  always_comb begin
    fire = tap_q[LAT-1];
    tap_d = (tap_q << 1) | LAT'(new_sum & armed_q);
    armed_d = armed_q | new_sum;
    bias_d = bias_q;
    if (bias_wr_en) bias_d[bias_wr_addr] = bias_wr_data;
    chan_d = fire ? (chan_q == CW'(NUM_OUT - 1) ? '0 : chan_q + CW'(1)) : chan_q;
    s1_d = fire ? {mac_in[BW-1], mac_in} + {bias_q[chan_q][BW-1], bias_q[chan_q]} : s1_q;
    s1_v_d = fire;
    s1_chan_d = fire ? chan_q : s1_chan_q;
    r = (RELU && s1_q[BW]) ? '0 : s1_q;
    s2_d = (r[BW] != r[BW-1]) ? {r[BW], {(BW-1){~r[BW]}}} : r[BW-1:0];
    s2_v_d = s1_v_q;
    s2_chan_d = s1_chan_q;
    out_valid = cnt_q != '0;
    pop = out_valid & out_ready;
    push = s2_v_q & ((cnt_q != (AW+1)'(FIFO_DEPTH)) | pop);
    ovf_d = ovf_q | (s2_v_q & ~push);
    mem_d = mem_q;
    if (push) mem_d[wr_q] = {s2_chan_q, s2_q};
    wr_d = wr_q + AW'(push);
    rd_d = rd_q + AW'(pop);
    cnt_d = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
    {out_chan, out_data} = out_valid ? mem_q[rd_q] : '0;
    fifo_count = cnt_q;
    overflow = ovf_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed_q <= 1'b0;
      tap_q <= '0;
      chan_q <= '0;
      s1_q <= '0;
      s1_v_q <= 1'b0;
      s1_chan_q <= '0;
      s2_q <= '0;
      s2_v_q <= 1'b0;
      s2_chan_q <= '0;
      bias_q <= '{default: '0};
      mem_q <= '{default: '0};
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      armed_q <= armed_d;
      tap_q <= tap_d;
      chan_q <= chan_d;
      s1_q <= s1_d;
      s1_v_q <= s1_v_d;
      s1_chan_q <= s1_chan_d;
      s2_q <= s2_d;
      s2_v_q <= s2_v_d;
      s2_chan_q <= s2_chan_d;
      bias_q <= bias_d;
      mem_q <= mem_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end
endmodule

// File: tb/tb_mac_output_stage.sv
// tb_mac_output_stage: directed and random checks of mac_output_stage (ReLU and signed builds) against a timestamp model
module tb_mac_output_stage;
  localparam int LAT = 3;
  localparam int DEPTH = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic new_sum = 1'b0;
  logic [15:0] mac_in = '0;
  logic bias_wr_en = 1'b0;
  logic [3:0] bias_wr_addr = '0;
  logic [15:0] bias_wr_data = '0;
  logic out_ready = 1'b0;
  logic v1, v0, o1, o0;
  logic [15:0] d1, d0;
  logic [3:0] c1, c0;
  logic [2:0] n1, n0;
  int total = 0;
  int bad = 0;

  mac_output_stage #(.BW(16), .LAT(LAT), .NUM_OUT(16), .FIFO_DEPTH(DEPTH), .RELU(1'b1)) u_r (
    .clk(clk), .rst_n(rst_n), .new_sum(new_sum), .mac_in(mac_in), .bias_wr_en(bias_wr_en),
    .bias_wr_addr(bias_wr_addr), .bias_wr_data(bias_wr_data), .out_ready(out_ready),
    .out_valid(v1), .out_data(d1), .out_chan(c1), .fifo_count(n1), .overflow(o1));
  mac_output_stage #(.BW(16), .LAT(LAT), .NUM_OUT(16), .FIFO_DEPTH(DEPTH), .RELU(1'b0)) u_n (
    .clk(clk), .rst_n(rst_n), .new_sum(new_sum), .mac_in(mac_in), .bias_wr_en(bias_wr_en),
    .bias_wr_addr(bias_wr_addr), .bias_wr_data(bias_wr_data), .out_ready(out_ready),
    .out_valid(v0), .out_data(d0), .out_chan(c0), .fifo_count(n0), .overflow(o0));

  always #5 clk = ~clk;

  typedef struct {int t; logic [3:0] ch; logic [15:0] dr; logic [15:0] ds;} ent_t;
  int cyc = 0;
  int cap[$];
  ent_t pipe[$];
  ent_t fifo[$];
  logic m_armed = 1'b0;
  logic m_ovf = 1'b0;
  logic [3:0] m_chan = '0;
  logic [15:0] m_bias [16] = '{default: '0};

  function automatic logic [15:0] act(int v, bit relu);
    int x = (relu && v < 0) ? 0 : v;
    x = x > 32767 ? 32767 : (x < -32768 ? -32768 : x);
    return x[15:0];
  endfunction

  task automatic chk(string n, logic [31:0] a, logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s at t=%0t: got %h expected %h", n, $time, a, e);
    end
  endtask

  task automatic model_step();
    int sz;
    bit pop;
    ent_t e;
    int v;
    if (!rst_n) begin
      cyc = 0; cap.delete(); pipe.delete(); fifo.delete();
      m_armed = 0; m_ovf = 0; m_chan = 0; m_bias = '{default: '0};
      return;
    end
    cyc++;
    sz = fifo.size();
    pop = sz > 0 && out_ready;
    if (pop) void'(fifo.pop_front());
    if (pipe.size() > 0 && pipe[0].t == cyc) begin
      e = pipe.pop_front();
      if (sz < DEPTH || pop) fifo.push_back(e);
      else m_ovf = 1;
    end
    if (cap.size() > 0 && cap[0] == cyc) begin
      void'(cap.pop_front());
      v = int'($signed(mac_in)) + int'($signed(m_bias[m_chan]));
      pipe.push_back('{cyc + 2, m_chan, act(v, 1), act(v, 0)});
      m_chan = m_chan + 4'd1;
    end
    if (new_sum) begin
      if (m_armed) cap.push_back(cyc + LAT);
      m_armed = 1;
    end
    if (bias_wr_en) m_bias[bias_wr_addr] = bias_wr_data;
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    chk("valid_r", v1, fifo.size() != 0);
    chk("valid_s", v0, fifo.size() != 0);
    chk("count_r", n1, fifo.size());
    chk("count_s", n0, fifo.size());
    chk("ovf_r", o1, m_ovf);
    chk("ovf_s", o0, m_ovf);
    if (fifo.size() != 0) begin
      chk("data_r", d1, fifo[0].dr);
      chk("data_s", d0, fifo[0].ds);
      chk("chan_r", c1, fifo[0].ch);
      chk("chan_s", c0, fifo[0].ch);
    end
  end

  task automatic do_reset();
    @(negedge clk);
    #2 rst_n = 0; new_sum = 0; bias_wr_en = 0;
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic wr_bias(input logic [3:0] a, input logic [15:0] d);
    @(negedge clk);
    bias_wr_en = 1; bias_wr_addr = a; bias_wr_data = d;
    @(negedge clk);
    bias_wr_en = 0;
  endtask

  task automatic arm();
    @(negedge clk);
    new_sum = 1;
    @(negedge clk);
    new_sum = 0;
  endtask

  task automatic do_sum(input logic [15:0] v);
    @(negedge clk);
    new_sum = 1;
    @(negedge clk);
    new_sum = 0;
    repeat (LAT - 1) @(negedge clk);
    mac_in = v;
  endtask

  task automatic wait_valid(output int k);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!v1 && k < 20);
  endtask

  initial begin
    int k;
    out_ready = 1;
    do_reset();
    chk("rst_valid", v1, 0);
    chk("rst_count", n1, 0);
    wr_bias(4'd0, 16'd5);
    wr_bias(4'd1, 16'hFFF6);
    wr_bias(4'd2, 16'h0100);
    wr_bias(4'd3, 16'hFFF0);
    arm();
    repeat (30) @(negedge clk);
    do_sum(16'd100);
    wait_valid(k);
    chk("t1_latency", k, 3);
    chk("t1_data", d1, 16'd105);
    chk("t1_chan", c1, 0);
    @(negedge clk);
    chk("t1_one_cycle", v1, 0);
    do_sum(16'd4);
    wait_valid(k);
    chk("t2_relu", d1, 16'h0000);
    chk("t2_signed", d0, 16'hFFFA);
    chk("t2_chan", c1, 1);
    do_sum(16'h7FF0);
    wait_valid(k);
    chk("t3_pos_sat_r", d1, 16'h7FFF);
    chk("t3_pos_sat_s", d0, 16'h7FFF);
    do_sum(16'h8005);
    wait_valid(k);
    chk("t3_neg_sat_s", d0, 16'h8000);
    chk("t3_neg_relu", d1, 16'h0000);
    do_reset();
    out_ready = 1;
    arm();
    repeat (8) @(negedge clk);
    chk("t5_arm_no_out", v1, 0);
    chk("t5_arm_count", n1, 0);
    for (int i = 0; i < 17; i++) begin
      do_sum(16'($urandom));
      wait_valid(k);
      chk("t5_chan_seq", c1, i % 16);
    end
    do_reset();
    out_ready = 0;
    arm();
    for (int i = 0; i < 6; i++) do_sum(16'($urandom));
    repeat (6) @(negedge clk);
    chk("t4_count", n1, 4);
    chk("t4_ovf", o1, 1);
    for (int i = 0; i < 4; i++) begin
      chk("t4_drain_chan", c1, i);
      out_ready = 1;
      @(negedge clk);
    end
    chk("t4_drained", n1, 0);
    do_sum(16'($urandom));
    wait_valid(k);
    chk("t4_next_chan", c1, 6);
    chk("t4_ovf_sticky", o1, 1);
    do_reset();
    out_ready = 0;
    arm();
    do_sum(16'd7);
    do_sum(16'd8);
    repeat (6) @(negedge clk);
    chk("t6_queued", n1, 2);
    do_reset();
    chk("t6_valid", v1, 0);
    chk("t6_count", n1, 0);
    chk("t6_ovf", o1, 0);
    out_ready = 1;
    arm();
    do_sum(16'd9);
    wait_valid(k);
    chk("t6_restart_chan", c1, 0);
    chk("t6_restart_data", d1, 16'd9);
    for (int i = 0; i < 900; i++) begin
      if (i == 450) do_reset();
      @(negedge clk);
      new_sum = ($urandom % 3) == 0;
      mac_in = 16'($urandom);
      bias_wr_en = ($urandom % 5) == 0;
      bias_wr_addr = 4'($urandom);
      bias_wr_data = 16'($urandom);
      out_ready = (i % 200 < 60) ? (($urandom % 4) == 0) : (($urandom % 4) != 0);
    end
    new_sum = 0;
    bias_wr_en = 0;
    repeat (10) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
